// File: rtl/amm_perf_meter.sv
// amm_perf_meter: passive Avalon-MM performance meter.
// Snoops one Avalon-MM master port and counts accepted write beats, written bytes,
// read requests and returned read beats. Per-transaction read latency (min/max/sum)
// is measured by stamping each accepted read into an outstanding-request FIFO and
// comparing against the tick timer on the first returned beat.
//
// Ports:
//   clk_i            memory clock (sole clock)
//   rst_i            asynchronous active-low reset
//   start_i          pulse: clear all results and enter RUN (wins over stop_i)
//   stop_i           pulse: stop counting new commands, drain outstanding reads
//   read_i/write_i   snooped command strobes
//   waitrequest_i    snooped waitrequest; command accepted when strobe & ~waitrequest_i
//   burstcount_i     snooped burstcount (0 treated as 1)
//   byteenable_i     snooped byteenable
//   readdatavalid_i  snooped read-data beat strobe
//   busy_o           high in RUN or DRAIN
//   overflow_o       sticky: read accepted while the FIFO was full (latency frozen)
//   proto_err_o      sticky: read beat seen with no outstanding transaction
//   wr_beats_o, wr_bytes_o, rd_reqs_o, rd_beats_o   saturating event counters
//   lat_min_o, lat_max_o, lat_sum_o                 read latency statistics in ticks
module amm_perf_meter #(
  parameter int unsigned AMM_DATA_W  = 128,
  parameter int unsigned AMM_BURST_W = 11,
  parameter int unsigned OUTST_DEPTH = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    read_i,
  input  logic                    write_i,
  input  logic                    waitrequest_i,
  input  logic [AMM_BURST_W-1:0]  burstcount_i,
  input  logic [AMM_DATA_W/8-1:0] byteenable_i,
  input  logic                    readdatavalid_i,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic                    proto_err_o,
  output logic [CNT_W-1:0]        wr_beats_o,
  output logic [CNT_W-1:0]        wr_bytes_o,
  output logic [CNT_W-1:0]        rd_reqs_o,
  output logic [CNT_W-1:0]        rd_beats_o,
  output logic [CNT_W-1:0]        lat_min_o,
  output logic [CNT_W-1:0]        lat_max_o,
  output logic [CNT_W-1:0]        lat_sum_o
);

  localparam int unsigned BE_W   = AMM_DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(OUTST_DEPTH);
  localparam int unsigned FCNT_W = $clog2(OUTST_DEPTH + 1);
  localparam int unsigned PC_W   = $clog2(BE_W + 1);
  // Wide enough to hold counter + popcount without losing the carry.
  localparam int unsigned WIDE_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_tick;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [FCNT_W-1:0]      r_fifo_cnt;
  logic [AMM_BURST_W-1:0] r_beats_left;
  logic                   r_overflow;
  logic                   r_proto_err;
  logic [CNT_W-1:0]       r_wr_beats;
  logic [CNT_W-1:0]       r_wr_bytes;
  logic [CNT_W-1:0]       r_rd_reqs;
  logic [CNT_W-1:0]       r_rd_beats;
  logic [CNT_W-1:0]       r_lat_min;
  logic [CNT_W-1:0]       r_lat_max;
  logic [CNT_W-1:0]       r_lat_sum;
  logic [CNT_W-1:0]       r_stamp_mem [OUTST_DEPTH];
  logic [AMM_BURST_W-1:0] r_burst_mem [OUTST_DEPTH];

  logic                   w_run;
  logic                   w_active;
  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic                   w_beat;
  logic                   w_empty;
  logic                   w_full;
  logic [CNT_W-1:0]       w_head_stamp;
  logic [AMM_BURST_W-1:0] w_head_burst;
  logic [AMM_BURST_W-1:0] w_head_len;
  logic                   w_first;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_ovf_evt;
  logic [FCNT_W-1:0]      w_fifo_cnt_nxt;
  logic [CNT_W-1:0]       w_lat;
  logic                   w_lat_upd;
  logic [PC_W-1:0]        w_be_cnt;
  logic [WIDE_W-1:0]      w_bytes_sum;
  logic [CNT_W-1:0]       w_bytes_nxt;
  logic [1:0]             w_state_nxt;

  assign w_run    = (r_state == ST_RUN);
  assign w_active = (r_state != ST_IDLE);
  assign w_wr_acc = w_run & write_i & ~waitrequest_i;
  assign w_rd_acc = w_run & read_i & ~waitrequest_i;
  // Beats of reads already in flight keep arriving during DRAIN.
  assign w_beat   = w_active & readdatavalid_i;

  assign w_empty      = (r_fifo_cnt == '0);
  assign w_full       = (r_fifo_cnt == FCNT_W'(OUTST_DEPTH));
  assign w_head_stamp = r_stamp_mem[r_rd_ptr];
  assign w_head_burst = r_burst_mem[r_rd_ptr];
  assign w_head_len   = (w_head_burst == '0) ? AMM_BURST_W'(1) : w_head_burst;

  // r_beats_left == 0 means the next beat opens the head transaction.
  assign w_first   = w_beat & ~w_empty & (r_beats_left == '0);
  assign w_pop     = w_beat & ~w_empty &
                     (((r_beats_left == '0) && (w_head_len == AMM_BURST_W'(1))) ||
                      (r_beats_left == AMM_BURST_W'(1)));
  // A simultaneous pop frees a slot, so a push into a full FIFO is still legal.
  assign w_push    = w_rd_acc & (~w_full | w_pop);
  assign w_ovf_evt = w_rd_acc & w_full & ~w_pop;

  assign w_fifo_cnt_nxt = r_fifo_cnt + FCNT_W'(w_push) - FCNT_W'(w_pop);

  // Modulo subtraction handles tick timer wrap.
  assign w_lat     = r_tick - w_head_stamp;
  assign w_lat_upd = w_first & ~r_overflow;

  always_comb begin
    w_be_cnt = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      w_be_cnt = w_be_cnt + PC_W'(byteenable_i[i]);
    end
  end

  assign w_bytes_sum = WIDE_W'(r_wr_bytes) + WIDE_W'(w_be_cnt);
  assign w_bytes_nxt = (w_bytes_sum > WIDE_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                              : w_bytes_sum[CNT_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    if (start_i) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_RUN: begin
          if (stop_i) w_state_nxt = (w_fifo_cnt_nxt == '0) ? ST_IDLE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_fifo_cnt_nxt == '0) w_state_nxt = ST_IDLE;
        end
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_tick       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_cnt   <= '0;
      r_beats_left <= '0;
      r_overflow   <= 1'b0;
      r_proto_err  <= 1'b0;
      r_wr_beats   <= '0;
      r_wr_bytes   <= '0;
      r_rd_reqs    <= '0;
      r_rd_beats   <= '0;
      r_lat_min    <= '1;
      r_lat_max    <= '0;
      r_lat_sum    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (start_i) begin
        // Events in the start cycle are discarded along with the old results.
        r_tick       <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_fifo_cnt   <= '0;
        r_beats_left <= '0;
        r_overflow   <= 1'b0;
        r_proto_err  <= 1'b0;
        r_wr_beats   <= '0;
        r_wr_bytes   <= '0;
        r_rd_reqs    <= '0;
        r_rd_beats   <= '0;
        r_lat_min    <= '1;
        r_lat_max    <= '0;
        r_lat_sum    <= '0;
      end else begin
        if (w_active) r_tick <= r_tick + CNT_W'(1);
        if (w_wr_acc) begin
          r_wr_beats <= sat_add(r_wr_beats, CNT_W'(1));
          r_wr_bytes <= w_bytes_nxt;
        end
        if (w_rd_acc) r_rd_reqs <= sat_add(r_rd_reqs, CNT_W'(1));
        if (w_beat) r_rd_beats <= sat_add(r_rd_beats, CNT_W'(1));
        if (w_beat && w_empty) r_proto_err <= 1'b1;
        if (w_ovf_evt) r_overflow <= 1'b1;
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_fifo_cnt <= w_fifo_cnt_nxt;
        if (w_beat && !w_empty) begin
          r_beats_left <= w_first ? (w_head_len - AMM_BURST_W'(1))
                                  : (r_beats_left - AMM_BURST_W'(1));
        end
        if (w_lat_upd) begin
          if (w_lat < r_lat_min) r_lat_min <= w_lat;
          if (w_lat > r_lat_max) r_lat_max <= w_lat;
          r_lat_sum <= sat_add(r_lat_sum, w_lat);
        end
      end
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (!start_i && w_push) begin
      r_stamp_mem[r_wr_ptr] <= r_tick;
      r_burst_mem[r_wr_ptr] <= burstcount_i;
    end
  end

  assign busy_o      = w_active;
  assign overflow_o  = r_overflow;
  assign proto_err_o = r_proto_err;
  assign wr_beats_o  = r_wr_beats;
  assign wr_bytes_o  = r_wr_bytes;
  assign rd_reqs_o   = r_rd_reqs;
  assign rd_beats_o  = r_rd_beats;
  assign lat_min_o   = r_lat_min;
  assign lat_max_o   = r_lat_max;
  assign lat_sum_o   = r_lat_sum;

endmodule

// File: tb/tb_amm_perf_meter.sv
module tb_amm_perf_meter;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tb_start = 1'b0, tb_stop = 1'b0, tb_read = 1'b0, tb_write = 1'b0;
  logic        tb_wreq = 1'b0, tb_rdv = 1'b0;
  logic [10:0] tb_bc = '0;
  logic [15:0] tb_be = '0;
  logic        busy, ovf, perr;
  logic [31:0] wr_beats, wr_bytes, rd_reqs, rd_beats, lat_min, lat_max, lat_sum;

  logic        s_start = 1'b0, s_write = 1'b0;
  logic        s_busy, s_ovf, s_perr;
  logic [3:0]  s_wr_beats, s_wr_bytes, s_rd_reqs, s_rd_beats, s_lat_min, s_lat_max, s_lat_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  amm_perf_meter u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(tb_start), .stop_i(tb_stop),
    .read_i(tb_read), .write_i(tb_write), .waitrequest_i(tb_wreq),
    .burstcount_i(tb_bc), .byteenable_i(tb_be), .readdatavalid_i(tb_rdv),
    .busy_o(busy), .overflow_o(ovf), .proto_err_o(perr),
    .wr_beats_o(wr_beats), .wr_bytes_o(wr_bytes), .rd_reqs_o(rd_reqs), .rd_beats_o(rd_beats),
    .lat_min_o(lat_min), .lat_max_o(lat_max), .lat_sum_o(lat_sum)
  );

  amm_perf_meter #(.CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .stop_i(1'b0),
    .read_i(1'b0), .write_i(s_write), .waitrequest_i(1'b0),
    .burstcount_i(11'd1), .byteenable_i(16'h0001), .readdatavalid_i(1'b0),
    .busy_o(s_busy), .overflow_o(s_ovf), .proto_err_o(s_perr),
    .wr_beats_o(s_wr_beats), .wr_bytes_o(s_wr_bytes), .rd_reqs_o(s_rd_reqs),
    .rd_beats_o(s_rd_beats), .lat_min_o(s_lat_min), .lat_max_o(s_lat_max),
    .lat_sum_o(s_lat_sum)
  );

  // Scoreboard: accepted reads are queued with their stamp; beats consume them.
  typedef struct {
    logic [31:0] stamp;
    logic [10:0] burst;
  } rd_t;
  rd_t         q_rd[$];
  int          m_state;  // 0 idle, 1 run, 2 drain
  logic [31:0] tk;
  int          m_left;
  int          m_wr_beats, m_wr_bytes, m_rd_reqs, m_rd_beats;
  logic [31:0] m_lat_min, m_lat_max, m_lat_sum;
  logic        m_ovf, m_perr;

  task automatic model_clear();
    q_rd.delete();
    tk = 0; m_left = 0;
    m_wr_beats = 0; m_wr_bytes = 0; m_rd_reqs = 0; m_rd_beats = 0;
    m_lat_min = 32'hFFFF_FFFF; m_lat_max = 0; m_lat_sum = 0;
    m_ovf = 0; m_perr = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, sample #1 after the edge.
  task automatic step(input logic i_rd, input logic i_wr, input logic i_rdv,
                      input logic [15:0] i_be, input logic [10:0] i_bc,
                      input logic i_st, input logic i_sp);
    bit          act, run, pop;
    logic [31:0] lat;
    int          blen;
    tb_read = i_rd; tb_write = i_wr; tb_rdv = i_rdv; tb_be = i_be; tb_bc = i_bc;
    tb_start = i_st; tb_stop = i_sp;
    act = (m_state != 0);
    run = (m_state == 1);
    pop = 0;
    if (i_st) begin
      model_clear();
      m_state = 1;
    end else begin
      if (run && i_wr) begin
        m_wr_beats++;
        m_wr_bytes += $countones(i_be);
      end
      if (act && i_rdv) begin
        m_rd_beats++;
        if (q_rd.size() == 0) begin
          m_perr = 1;
        end else if (m_left == 0) begin
          lat = tk - q_rd[0].stamp;
          if (!m_ovf) begin
            if (lat < m_lat_min) m_lat_min = lat;
            if (lat > m_lat_max) m_lat_max = lat;
            m_lat_sum += lat;
          end
          blen = (q_rd[0].burst == 0) ? 1 : int'(q_rd[0].burst);
          if (blen == 1) pop = 1;
          else m_left = blen - 1;
        end else begin
          m_left--;
          if (m_left == 0) pop = 1;
        end
      end
      if (run && i_rd) begin
        m_rd_reqs++;
        if (q_rd.size() == DEPTH && !pop) m_ovf = 1;
        else q_rd.push_back('{stamp: tk, burst: i_bc});
      end
      if (pop) void'(q_rd.pop_front());
      if (run && i_sp) m_state = (q_rd.size() == 0) ? 0 : 2;
      else if (m_state == 2 && q_rd.size() == 0) m_state = 0;
    end
    @(posedge clk);
    #1;
    if (i_st) tk = 0;
    else if (act) tk = tk + 1;
    tb_read = 0; tb_write = 0; tb_rdv = 0; tb_start = 0; tb_stop = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 11'd1, 0, 0);
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || ovf !== 1'b0 || perr !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b ovf=%b perr=%b want 0 0 0", busy, ovf, perr);
    end
    checks++;
    if ({wr_beats, wr_bytes, rd_reqs, rd_beats} !== 128'h0) begin
      errors++;
      $display("FAIL reset_counters got %0d %0d %0d %0d want 0", wr_beats, wr_bytes, rd_reqs,
               rd_beats);
    end
    checks++;
    if (lat_min !== 32'hFFFF_FFFF || lat_max !== 32'h0 || lat_sum !== 32'h0) begin
      errors++;
      $display("FAIL reset_lat got min=%h max=%h sum=%h want ffffffff 0 0", lat_min, lat_max,
               lat_sum);
    end
  endtask

  task automatic test_writes();
    step(0, 0, 0, 16'h0, 11'd1, 1, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", busy); end
    step(0, 1, 0, 16'hFFFF, 11'd1, 0, 0);
    step(0, 1, 0, 16'h00FF, 11'd1, 0, 0);
    step(0, 1, 0, 16'h0001, 11'd1, 0, 0);
    step(0, 1, 0, 16'h0000, 11'd1, 0, 0);
    checks++;
    if (wr_beats !== 32'd4 || wr_beats !== 32'(m_wr_beats)) begin
      errors++; $display("FAIL wr_beats got %0d want 4", wr_beats);
    end
    checks++;
    if (wr_bytes !== 32'd25 || wr_bytes !== 32'(m_wr_bytes)) begin
      errors++; $display("FAIL wr_bytes got %0d want 25", wr_bytes);
    end
  endtask

  task automatic test_latency();
    step(0, 0, 0, 16'h0, 11'd1, 1, 0);
    idle(1);                                       // tick 0
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0, 11'd1, 0, 0);  // ticks 1..3
    idle(2);                                       // ticks 4,5
    step(0, 0, 1, 16'h0, 11'd1, 0, 0);             // tick 6
    idle(2);                                       // ticks 7,8
    step(0, 0, 1, 16'h0, 11'd1, 0, 0);             // tick 9
    step(0, 0, 1, 16'h0, 11'd1, 0, 0);             // tick 10
    checks++;
    if (rd_reqs !== 32'(m_rd_reqs) || rd_beats !== 32'(m_rd_beats)) begin
      errors++;
      $display("FAIL lat_counts got reqs=%0d beats=%0d want %0d %0d", rd_reqs, rd_beats,
               m_rd_reqs, m_rd_beats);
    end
    checks++;
    if (lat_min !== m_lat_min || lat_max !== m_lat_max) begin
      errors++;
      $display("FAIL lat_minmax got %0d/%0d want %0d/%0d", lat_min, lat_max, m_lat_min,
               m_lat_max);
    end
    checks++;
    if (lat_sum !== m_lat_sum) begin
      errors++; $display("FAIL lat_sum got %0d want %0d", lat_sum, m_lat_sum);
    end
  endtask

  task automatic test_drain();
    step(0, 0, 0, 16'h0, 11'd1, 1, 0);
    step(1, 0, 0, 16'h0, 11'd4, 0, 0);             // tick 0
    idle(1);                                       // tick 1
    step(0, 0, 0, 16'h0, 11'd1, 0, 1);             // tick 2: stop
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_stop got %b want 1", busy); end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0, 11'd1, 0, 0);  // ticks 3..5
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_mid got %b want 1", busy); end
    step(0, 0, 1, 16'h0, 11'd1, 0, 0);             // tick 6: last beat
    checks++;
    if (busy !== 1'b0 || m_state != 0) begin
      errors++; $display("FAIL drain_busy_end got %b want 0", busy);
    end
    checks++;
    if (lat_min !== m_lat_min || lat_max !== m_lat_max || rd_beats !== 32'(m_rd_beats)) begin
      errors++;
      $display("FAIL drain_lat got min=%0d max=%0d beats=%0d want %0d %0d %0d", lat_min, lat_max,
               rd_beats, m_lat_min, m_lat_max, m_rd_beats);
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 16'h0, 11'd1, 1, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, 16'h0, 11'd1, 0, 0);
    checks++;
    if (ovf !== 1'b1 || rd_reqs !== 32'd17) begin
      errors++; $display("FAIL ovf_set got ovf=%b reqs=%0d want 1 17", ovf, rd_reqs);
    end
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 16'h0, 11'd1, 0, 0);
    checks++;
    if (lat_min !== 32'hFFFF_FFFF || lat_max !== 32'h0 || lat_sum !== 32'h0 ||
        rd_beats !== 32'(m_rd_beats)) begin
      errors++;
      $display("FAIL ovf_frozen got min=%h max=%0d sum=%0d beats=%0d want ffffffff 0 0 %0d",
               lat_min, lat_max, lat_sum, rd_beats, m_rd_beats);
    end
    step(0, 0, 0, 16'h0, 11'd1, 1, 0);
    checks++;
    if (ovf !== 1'b0 || rd_reqs !== 32'd0 || rd_beats !== 32'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%b reqs=%0d beats=%0d busy=%b want 0 0 0 1", ovf, rd_reqs,
               rd_beats, busy);
    end
  endtask

  task automatic test_proto();
    step(0, 0, 0, 16'h0, 11'd1, 1, 0);
    step(0, 0, 1, 16'h0, 11'd1, 0, 0);
    checks++;
    if (perr !== 1'b1 || rd_beats !== 32'd1 || lat_min !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL proto got perr=%b beats=%0d min=%h want 1 1 ffffffff", perr, rd_beats,
               lat_min);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, 16'h0, 11'd1, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 16'h0, 11'd0, 0, 0);  // burst 0 acts as 1
    step(1, 0, 1, 16'h0, 11'd1, 0, 0);             // push + pop while full
    checks++;
    if (ovf !== 1'b0 || rd_reqs !== 32'(m_rd_reqs) || lat_max !== m_lat_max) begin
      errors++;
      $display("FAIL b2b_full got ovf=%b reqs=%0d max=%0d want 0 %0d %0d", ovf, rd_reqs, lat_max,
               m_rd_reqs, m_lat_max);
    end
    step(0, 0, 1, 16'h0, 11'd1, 0, 1);             // stop with reads outstanding
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 16'h0, 11'd1, 0, 0);
    checks++;
    if (busy !== 1'b0 || lat_min !== m_lat_min || lat_max !== m_lat_max ||
        lat_sum !== m_lat_sum || rd_beats !== 32'(m_rd_beats)) begin
      errors++;
      $display("FAIL b2b_drain got busy=%b min=%0d max=%0d sum=%0d beats=%0d want 0 %0d %0d %0d %0d",
               busy, lat_min, lat_max, lat_sum, rd_beats, m_lat_min, m_lat_max, m_lat_sum,
               m_rd_beats);
    end
  endtask

  task automatic test_saturate_and_reset();
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_write = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (s_wr_beats !== 4'hF || s_wr_bytes !== 4'hF) begin
      errors++;
      $display("FAIL sat got beats=%0d bytes=%0d want 15 15", s_wr_beats, s_wr_bytes);
    end
    // Main DUT gets a busy run going so the async reset has state to clear.
    step(0, 0, 0, 16'h0, 11'd1, 1, 0);
    step(1, 1, 0, 16'hFFFF, 11'd1, 0, 0);
    #2 rst = 1'b0;                                 // mid-cycle, away from any edge
    #1;
    checks++;
    if (busy !== 1'b0 || wr_beats !== 32'd0 || rd_reqs !== 32'd0 ||
        lat_min !== 32'hFFFF_FFFF || s_wr_beats !== 4'd0 || s_busy !== 1'b0 ||
        s_lat_min !== 4'hF) begin
      errors++;
      $display("FAIL async_rst got busy=%b wr=%0d rq=%0d min=%h s_wr=%0d s_busy=%b s_min=%h",
               busy, wr_beats, rd_reqs, lat_min, s_wr_beats, s_busy, s_lat_min);
    end
    s_write = 1'b0;
  endtask

  initial begin
    model_clear();
    m_state = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    test_reset();
    test_writes();
    test_latency();
    test_drain();
    test_overflow();
    test_proto();
    test_back_to_back();
    test_saturate_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
